match_irq_ctrl: RTL

//  Downstream consumer of the counter/comparator SoC stage: turns the level `match`

---
 rtl/match_irq_ctrl_if.sv | 40 ++++
 rtl/match_irq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/match_irq_ctrl_if.sv
// Bus bundle for match_irq_ctrl.
//   slave  : the controller side (takes match/count/irq_ack/clr_ovf, drives the rest)
//   master : the producer/consumer side driving the controller
// Signals:
//   match      comparator level from the counter stage
//   count      counter value, snapshotted on each match rising edge
//   irq_ack    consumer acknowledge of the event currently signalled
//   clr_ovf    clears the sticky overflow flag
//   irq        interrupt request, held until acknowledged
//   irq_count  snapshot belonging to the event being signalled
//   pending    queued events, including the one being signalled
//   evt_total  saturating count of match rising edges
//   overflow   sticky flag: an event was dropped because the queue was full
interface match_irq_ctrl_if #(
  parameter int CNT_W    = 4,
  parameter int EVT_W    = 8,
  parameter int PEND_MAX = 3
);
  localparam int PEND_W = $clog2(PEND_MAX + 1);

  logic              match;
  logic [CNT_W-1:0]  count;
  logic              irq_ack;
  logic              clr_ovf;
  logic              irq;
  logic [CNT_W-1:0]  irq_count;
  logic [PEND_W-1:0] pending;
  logic [EVT_W-1:0]  evt_total;
  logic              overflow;

  modport master (
    output match, count, irq_ack, clr_ovf,
    input  irq, irq_count, pending, evt_total, overflow
  );

  modport slave (
    input  match, count, irq_ack, clr_ovf,
    output irq, irq_count, pending, evt_total, overflow
  );
endinterface

// File: rtl/match_irq_ctrl.sv
// match_irq_ctrl: turns the level match output of the counter/comparator stage
// into queued, acknowledged interrupt events.
//   - rising edges of match are counted (saturating) and the current count is
//     snapshotted into a PEND_MAX-deep FIFO; a rise with the FIFO full and no
//     pop in the same cycle is dropped and sets the sticky overflow flag
//   - one event at a time is presented on irq/irq_count until irq_ack
//   - after each ack irq is held low for HOLDOFF cycles before the next event
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    match_irq_ctrl_if.slave (match, count, irq_ack, clr_ovf in;
//          irq, irq_count, pending, evt_total, overflow out, all registered)
module match_irq_ctrl #(
  parameter int CNT_W    = 4,
  parameter int EVT_W    = 8,
  parameter int PEND_MAX = 3,
  parameter int HOLDOFF  = 4
) (
  input  logic             clk,
  input  logic             reset,
  match_irq_ctrl_if.slave  bus
);

  localparam int PEND_W = $clog2(PEND_MAX + 1);
  localparam int PTR_W  = (PEND_MAX > 1) ? $clog2(PEND_MAX) : 1;
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PEND_MAX - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                match_q,     match_d;
  logic [CNT_W-1:0]    fifo_q [PEND_MAX];
  logic [CNT_W-1:0]    fifo_d [PEND_MAX];
  logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [PEND_W-1:0]   pending_q,   pending_d;
  logic                irq_q,       irq_d;
  logic [CNT_W-1:0]    irq_count_q, irq_count_d;
  logic [EVT_W-1:0]    evt_total_q, evt_total_d;
  logic                overflow_q,  overflow_d;
  logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;

  logic rise;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == '1) ? v : v + EVT_W'(1);
  endfunction

  assign rise = bus.match & ~match_q;
  assign full = (pending_q == PEND_FULL);
  // ASSERT is only entered with a non-empty FIFO and left on the pop, so a
  // pop can never underflow.
  assign pop  = (state_q == ST_ASSERT) & bus.irq_ack;
  // A pop in the same cycle frees the slot, so a rise into a full FIFO is kept.
  assign push = rise & (~full | pop);
  assign drop = rise & full & ~pop;

  // Stage 0: edge detect, event FIFO, counters
  always_comb begin
    match_d     = bus.match;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pending_d   = pending_q;
    evt_total_d = evt_total_q;
    overflow_d  = overflow_q;

    if (rise) begin
      evt_total_d = sat_inc(evt_total_q);
    end

    if (push) begin
      fifo_d[wr_ptr_q] = bus.count;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   pending_d = pending_q + PEND_W'(1);
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: pending_d = pending_q;
    endcase

    // A drop in the same cycle as clr_ovf leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Stage 1: interrupt presentation FSM
  always_comb begin
    state_d     = state_q;
    irq_d       = irq_q;
    irq_count_d = irq_count_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        irq_d = 1'b0;
        if (pending_q != '0) begin
          state_d     = ST_ASSERT;
          irq_d       = 1'b1;
          irq_count_d = fifo_q[rd_ptr_q];
        end
      end
      ST_ASSERT: begin
        if (bus.irq_ack) begin
          state_d    = ST_HOLD;
          irq_d      = 1'b0;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        irq_d = 1'b0;
        if (hold_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      match_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pending_q   <= '0;
      irq_q       <= 1'b0;
      irq_count_q <= '0;
      evt_total_q <= '0;
      overflow_q  <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_q   <= pending_d;
      irq_q       <= irq_d;
      irq_count_q <= irq_count_d;
      evt_total_q <= evt_total_d;
      overflow_q  <= overflow_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Storage is never read past the occupancy count, so flushing the pointers
  // on reset is enough; the entries themselves are left unreset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.irq       = irq_q;
  assign bus.irq_count = irq_count_q;
  assign bus.pending   = pending_q;
  assign bus.evt_total = evt_total_q;
  assign bus.overflow  = overflow_q;

endmodule
